// File: rtl/uart_rx_frame.sv
// Parametrised asynchronous serial receiver: configurable data width, parity, stop bits, bit period.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around every mid-bit sample.
module uart_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = 521,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 rx_clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_out,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID_START = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] MID_BIT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_HIGH
  } state_t;

  state_t state, state_n;

  logic rx_meta, rx_s;
  logic rx_line, rx_bit, line_prev;

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // FSM runs one cycle behind rx_s so the vote can include the mid+1 sample.
  logic rx_d1, rx_d2;
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end
  assign rx_line = rx_d1;
  assign rx_bit  = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  assign rx_line = rx_s;
  assign rx_bit  = rx_s;
`endif

  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, stop_low, first_stop_low;
  logic                 cnt_clr, start_ok, data_smp, par_smp, stop_smp, done_go;
  logic                 bit_tick, par_xor, par_err_w, brk_w;

  assign bit_tick = (cnt == MID_BIT);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    start_ok = 1'b0;
    data_smp = 1'b0;
    par_smp  = 1'b0;
    stop_smp = 1'b0;
    done_go  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (line_prev && !rx_line) begin
          state_n = S_START;
          cnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (cnt == MID_START) begin
          cnt_clr = 1'b1;
          if (rx_bit) begin
            state_n = S_IDLE;
          end else begin
            state_n  = S_DATA;
            start_ok = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_clr  = 1'b1;
          data_smp = 1'b1;
          if (bit_idx == LAST_DATA) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          cnt_clr = 1'b1;
          par_smp = 1'b1;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_clr  = 1'b1;
          stop_smp = 1'b1;
          if (stop_idx == LAST_STOP) begin
            done_go = 1'b1;
            state_n = S_DONE;
          end
        end
      end
      S_DONE:      state_n = rx_line ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_line) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Flags are formed from the final stop sample in the same cycle it is taken.
  assign par_xor   = (^shreg) ^ par_bit;
  assign par_err_w = (PARITY == 1) ? ~par_xor : (PARITY == 2) ? par_xor : 1'b0;
  assign brk_w     = (shreg == '0) && ((PARITY == 0) || !par_bit)
                     && (stop_idx ? first_stop_low : !rx_bit);

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      line_prev      <= 1'b1;
      cnt            <= '0;
      bit_idx        <= '0;
      stop_idx       <= 1'b0;
      shreg          <= '0;
      par_bit        <= 1'b0;
      stop_low       <= 1'b0;
      first_stop_low <= 1'b0;
      rx_out         <= '0;
      rx_valid       <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      break_det      <= 1'b0;
    end else begin
      line_prev <= rx_line;
      rx_valid  <= 1'b0;
      if (cnt_clr)             cnt <= '0;
      else if (cnt != MID_BIT) cnt <= cnt + 1'b1;
      if (start_ok) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        stop_low <= 1'b0;
        par_bit  <= 1'b0;
      end
      if (data_smp) begin
        shreg   <= {rx_bit, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (par_smp) par_bit <= rx_bit;
      if (stop_smp) begin
        stop_idx <= 1'b1;
        stop_low <= stop_low | !rx_bit;
        if (!stop_idx) first_stop_low <= !rx_bit;
      end
      if (done_go) begin
        rx_valid   <= 1'b1;
        rx_out     <= shreg;
        parity_err <= par_err_w;
        frame_err  <= stop_low | !rx_bit;
        break_det  <= brk_w;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: four parameterisations driven by directed and random frames,
// each strobe compared against a frame-level reference model.
module tb_uart_rx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rx0, rx1, rx2, rx3;

  logic [7:0] o0; logic v0, pe0, fe0, bd0, busy0;
  logic [6:0] o1; logic v1, pe1, fe1, bd1, busy1;
  logic [7:0] o2; logic v2, pe2, fe2, bd2, busy2;
  logic [8:0] o3; logic v3, pe3, fe3, bd3, busy3;

  uart_rx_frame dut0 (
    .rx_clk(clk), .rst(rst), .rx_in(rx0), .rx_out(o0), .rx_valid(v0),
    .parity_err(pe0), .frame_err(fe0), .break_det(bd0), .busy(busy0));

  uart_rx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
    .rx_clk(clk), .rst(rst), .rx_in(rx1), .rx_out(o1), .rx_valid(v1),
    .parity_err(pe1), .frame_err(fe1), .break_det(bd1), .busy(busy1));

  uart_rx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
    .rx_clk(clk), .rst(rst), .rx_in(rx2), .rx_out(o2), .rx_valid(v2),
    .parity_err(pe2), .frame_err(fe2), .break_det(bd2), .busy(busy2));

  uart_rx_frame #(.CLKS_PER_BIT(9), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) dut3 (
    .rx_clk(clk), .rst(rst), .rx_in(rx3), .rx_out(o3), .rx_valid(v3),
    .parity_err(pe3), .frame_err(fe3), .break_det(bd3), .busy(busy3));

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bd;
  } rec_t;

  rec_t q0[$], q1[$], q2[$], q3[$];
  int n_assert = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    if (v0 === 1'b1) q0.push_back(rec_t'{{1'b0, o0}, pe0, fe0, bd0});
    if (v1 === 1'b1) q1.push_back(rec_t'{{2'b0, o1}, pe1, fe1, bd1});
    if (v2 === 1'b1) q2.push_back(rec_t'{{1'b0, o2}, pe2, fe2, bd2});
    if (v3 === 1'b1) q3.push_back(rec_t'{o3, pe3, fe3, bd3});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: what the receiver should report for the bits placed on the wire.
  function automatic rec_t model(input logic [8:0] d, input int par, input logic pbit,
                                 input int nstop, input logic [1:0] stops);
    rec_t r;
    int ones;
    ones = $countones(d);
    r.d  = d;
    r.pe = (par == 0) ? 1'b0 : (par == 1) ? ((ones + pbit) % 2 == 0) : ((ones + pbit) % 2 == 1);
    r.fe = !stops[0] || (nstop == 2 && !stops[1]);
    r.bd = (d == 9'd0) && (par == 0 || !pbit) && !stops[0];
    return r;
  endfunction

  task automatic drive(input int idx, input logic v, input int n);
    case (idx)
      0:       rx0 = v;
      1:       rx1 = v;
      2:       rx2 = v;
      default: rx3 = v;
    endcase
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int idx, input int cpb, input int nbits, input logic [8:0] d,
                      input int par, input logic pbit, input int nstop, input logic [1:0] stops);
    drive(idx, 1'b0, cpb);
    for (int i = 0; i < nbits; i++) drive(idx, d[i], cpb);
    if (par != 0) drive(idx, pbit, cpb);
    for (int i = 0; i < nstop; i++) drive(idx, stops[i], cpb);
  endtask

  task automatic take(input int idx, output int n, output rec_t r);
    r = rec_t'{9'h0, 1'b0, 1'b0, 1'b0};
    case (idx)
      0:       begin n = q0.size(); if (n > 0) r = q0[0]; q0.delete(); end
      1:       begin n = q1.size(); if (n > 0) r = q1[0]; q1.delete(); end
      2:       begin n = q2.size(); if (n > 0) r = q2[0]; q2.delete(); end
      default: begin n = q3.size(); if (n > 0) r = q3[0]; q3.delete(); end
    endcase
  endtask

  task automatic expect_frame(input int idx, input string tag, input rec_t exp);
    int n;
    rec_t r;
    take(idx, n, r);
    check({tag, " strobes"}, n, 1);
    if (n > 0) begin
      check({tag, " data"}, r.d, exp.d);
      check({tag, " parity_err"}, r.pe, exp.pe);
      check({tag, " frame_err"}, r.fe, exp.fe);
      check({tag, " break_det"}, r.bd, exp.bd);
    end
  endtask

  task automatic expect_none(input int idx, input string tag);
    int n;
    rec_t r;
    take(idx, n, r);
    check({tag, " strobes"}, n, 0);
  endtask

  task automatic rand_frame(input int idx, input int cpb, input int nbits, input int par,
                            input int nstop, input string tag);
    logic [8:0] d, mask;
    logic       pbit;
    logic [1:0] stops;
    mask  = 9'((1 << nbits) - 1);
    d     = 9'($urandom) & mask;
    pbit  = 1'($urandom);
    stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
    send(idx, cpb, nbits, d, par, pbit, nstop, stops);
    drive(idx, 1'b1, 2 * cpb);
    expect_frame(idx, tag, model(d, par, pbit, nstop, stops));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1; rx3 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rx_out", o0, 0);
    check("reset rx_valid", v0, 0);
    check("reset parity_err", pe0, 0);
    check("reset frame_err", fe0, 0);
    check("reset break_det", bd0, 0);
    check("reset busy", busy0, 0);
    rst = 1'b0;
    drive(0, 1'b1, 20);

    send(0, 521, 8, 9'h0E3, 0, 1'b0, 1, 2'b11);
    drive(0, 1'b1, 1042);
    expect_frame(0, "8N1 E3", model(9'h0E3, 0, 1'b0, 1, 2'b11));
    check("8N1 E3 busy after", busy0, 0);
    check("8N1 E3 rx_out held", o0, 8'hE3);

    // Abort 0x3C in the middle of data bit 4 with an asynchronous reset.
    drive(0, 1'b0, 521);
    for (int i = 0; i < 4; i++) drive(0, (i >= 2), 521);
    drive(0, 1'b1, 260);
    #3 rst = 1'b1;
    #1;
    check("async rst busy", busy0, 0);
    check("async rst rx_out", o0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1042);
    expect_none(0, "aborted 3C");
    send(0, 521, 8, 9'h081, 0, 1'b0, 1, 2'b11);
    drive(0, 1'b1, 1042);
    expect_frame(0, "after rst 81", model(9'h081, 0, 1'b0, 1, 2'b11));

    drive(0, 1'b0, 100);
    check("glitch busy", busy0, 1);
    drive(0, 1'b0, 100);
    drive(0, 1'b1, 1042);
    expect_none(0, "glitch");
    check("glitch busy after", busy0, 0);

    drive(0, 1'b0, 20 * 521);
    check("break busy while low", busy0, 1);
    expect_frame(0, "break", model(9'h000, 0, 1'b0, 1, 2'b00));
    drive(0, 1'b1, 1042);
    expect_none(0, "break release");
    check("break busy after", busy0, 0);

    for (int i = 0; i < 2; i++) rand_frame(0, 521, 8, 0, 1, "rand 8N1");

    send(1, 16, 7, 9'h055, 2, 1'b0, 1, 2'b11);
    drive(1, 1'b1, 32);
    expect_frame(1, "7E1 good", model(9'h055, 2, 1'b0, 1, 2'b11));
    send(1, 16, 7, 9'h055, 2, 1'b1, 1, 2'b11);
    drive(1, 1'b1, 32);
    expect_frame(1, "7E1 bad", model(9'h055, 2, 1'b1, 1, 2'b11));
    for (int i = 0; i < 6; i++) rand_frame(1, 16, 7, 2, 1, "rand 7E1");
    check("7E1 busy after", busy1, 0);

    send(2, 16, 8, 9'h0A5, 0, 1'b0, 2, 2'b01);
    drive(2, 1'b1, 32);
    expect_frame(2, "8N2 stop2 low", model(9'h0A5, 0, 1'b0, 2, 2'b01));
    for (int i = 0; i < 6; i++) rand_frame(2, 16, 8, 0, 2, "rand 8N2");
    check("8N2 busy after", busy2, 0);

    for (int i = 0; i < 8; i++) rand_frame(3, 9, 9, 1, 2, "rand 9O2");
    check("9O2 busy after", busy3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
